// File: rtl/cv32e40p_instr_match_unit.sv
// -----------------------------------------------------------------------------
// cv32e40p_instr_match_unit
//
// Watches the cv32e40p retire stream and matches each retired instruction
// against NUM_CH runtime-programmable mask/value channels. Every channel has a
// saturating occurrence counter and a sticky overflow flag. Retirements that
// hit at least one channel are queued as trace records {pc, instr, channel} in
// a small FIFO that drains to a debug/trace sink. Records that find the FIFO
// full are discarded and counted.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cfg_we_i, cfg_ch_i    config write strobe / channel select (also selects
//                         the counter shown on cnt_o)
//   cfg_en_i, cfg_mask_i,
//   cfg_value_i           new enable / mask / compare value for cfg_ch_i
//   clr_i                 clear counters, overflow flags, drop count, FIFO
//   retire_valid_i,
//   retire_instr_i,
//   retire_pc_i           retire stream, one instruction per cycle at most
//   cnt_o, ovf_o          counter of cfg_ch_i, sticky saturation flags
//   trace_valid_o, trace_ready_i,
//   trace_pc_o, trace_instr_o, trace_ch_o
//                         head record of the trace FIFO toward the sink
//   fifo_level_o          occupied FIFO entries
//   drop_cnt_o            saturating count of discarded records
//
// Trace handshake: trace_valid_o is high whenever the FIFO holds a record and
// the head fields are then valid; a record is transferred (popped) in any
// cycle where trace_valid_o && trace_ready_i at the rising edge. While
// trace_valid_o is high and trace_ready_i low, the head fields hold steady.
// trace_valid_o never depends on trace_ready_i.
// -----------------------------------------------------------------------------
module cv32e40p_instr_match_unit #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W     = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic              cfg_en_i,
    input  logic [31:0]       cfg_mask_i,
    input  logic [31:0]       cfg_value_i,
    input  logic              clr_i,
    input  logic              retire_valid_i,
    input  logic [31:0]       retire_instr_i,
    input  logic [31:0]       retire_pc_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [NUM_CH-1:0] ovf_o,
    output logic              trace_valid_o,
    input  logic              trace_ready_i,
    output logic [31:0]       trace_pc_o,
    output logic [31:0]       trace_instr_o,
    output logic [CH_W-1:0]   trace_ch_o,
    output logic [PTR_W:0]    fifo_level_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    typedef struct packed {
        logic [31:0]     pc;
        logic [31:0]     instr;
        logic [CH_W-1:0] ch;
    } rec_t;

    // ---------------------------------------------------------------- config
    logic [NUM_CH-1:0] en_q;
    logic [31:0]       mask_q  [NUM_CH];
    logic [31:0]       value_q [NUM_CH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                en_q[k]    <= 1'b0;
                mask_q[k]  <= '0;
                value_q[k] <= '0;
            end
        end else begin
            // clr_i deliberately leaves the channel configuration alone.
            for (int k = 0; k < NUM_CH; k++) begin
                if (cfg_we_i && (cfg_ch_i == CH_W'(k))) begin
                    en_q[k]    <= cfg_en_i;
                    mask_q[k]  <= cfg_mask_i;
                    value_q[k] <= cfg_value_i;
                end
            end
        end
    end

    // ------------------------------------------------------------- matching
    // Matching uses the registered config, so a same-cycle write only takes
    // effect for the following retirement.
    logic [NUM_CH-1:0] hit;
    logic [CH_W-1:0]   hit_ch;

    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            hit[k] = retire_valid_i && en_q[k] &&
                     ((retire_instr_i & mask_q[k]) == value_q[k]);
        end
    end

    // Walking downward leaves the lowest hitting index as the final value.
    always_comb begin
        hit_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (hit[k]) hit_ch = CH_W'(k);
        end
    end

    // ---------------------------------------------------- counters and ovf
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
            ovf_q <= '0;
        end else if (clr_i) begin
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
            ovf_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (hit[k]) begin
                    // A hit on a counter already at all-ones is the overflow
                    // event; the counter itself stays pinned.
                    if (cnt_q[k] == '1) ovf_q[k] <= 1'b1;
                    else                cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Out-of-range channel numbers (non power-of-two NUM_CH) read as zero.
    always_comb begin
        cnt_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cfg_ch_i == CH_W'(k)) cnt_o = cnt_q[k];
        end
    end

    assign ovf_o = ovf_q;

    // ------------------------------------------------------------ trace FIFO
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    rec_t              mem_q [FIFO_DEPTH];
    logic [DROP_W-1:0] drop_q;
    logic              empty, full, push_req, push_ok, pop, drop;
    rec_t              push_rec, head;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop      = !empty && trace_ready_i;
    assign push_req = |hit;
    // A full FIFO still accepts a record when the head leaves the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign push_rec.pc    = retire_pc_i;
    assign push_rec.instr = retire_instr_i;
    assign push_rec.ch    = hit_ch;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers,
    // and the output mux forces zeros while empty.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clr_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_rec;
    end

    assign head          = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign trace_valid_o = !empty;
    assign trace_pc_o    = empty ? '0 : head.pc;
    assign trace_instr_o = empty ? '0 : head.instr;
    assign trace_ch_o    = empty ? '0 : head.ch;
    assign fifo_level_o  = wr_ptr_q - rd_ptr_q;
    assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_cv32e40p_instr_match_unit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cv32e40p_instr_match_unit (NUM_CH=4, CNT_W=8,
// FIFO_DEPTH=4, DROP_W=16). A queue-based reference model predicts every
// output after each clock edge; directed steps follow the test plan, then a
// randomized phase, then an asynchronous reset in mid-operation.
// -----------------------------------------------------------------------------
module tb_cv32e40p_instr_match_unit;

    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int DROP_W     = 16;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
    localparam int DROP_MAX   = (1 << DROP_W) - 1;

    // ------------------------------------------------------ clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ DUT wiring
    logic              cfg_we = 0;
    logic [1:0]        cfg_ch = 0;
    logic              cfg_en = 0;
    logic [31:0]       cfg_mask = 0;
    logic [31:0]       cfg_value = 0;
    logic              clr = 0;
    logic              retire_valid = 0;
    logic [31:0]       retire_instr = 0;
    logic [31:0]       retire_pc = 0;
    logic              trace_ready = 0;
    logic [CNT_W-1:0]  cnt_o;
    logic [NUM_CH-1:0] ovf_o;
    logic              trace_valid_o;
    logic [31:0]       trace_pc_o;
    logic [31:0]       trace_instr_o;
    logic [1:0]        trace_ch_o;
    logic [2:0]        fifo_level_o;
    logic [DROP_W-1:0] drop_cnt_o;

    cv32e40p_instr_match_unit #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH), .DROP_W(DROP_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_en_i(cfg_en),
        .cfg_mask_i(cfg_mask), .cfg_value_i(cfg_value), .clr_i(clr),
        .retire_valid_i(retire_valid), .retire_instr_i(retire_instr),
        .retire_pc_i(retire_pc),
        .cnt_o(cnt_o), .ovf_o(ovf_o),
        .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready),
        .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
        .trace_ch_o(trace_ch_o), .fifo_level_o(fifo_level_o),
        .drop_cnt_o(drop_cnt_o)
    );

    // ------------------------------------------------------- reference model
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          ch;
    } rec_t;

    rec_t        exp_q[$];
    int          m_cnt  [NUM_CH];
    bit          m_ovf  [NUM_CH];
    bit          m_en   [NUM_CH];
    logic [31:0] m_mask [NUM_CH];
    logic [31:0] m_val  [NUM_CH];
    int          m_drop;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic model_reset();
        exp_q.delete();
        m_drop = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_cnt[k] = 0; m_ovf[k] = 0; m_en[k] = 0; m_mask[k] = 0; m_val[k] = 0;
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int  first;
        bit  hits [NUM_CH];
        bit  pop;
        rec_t r;
        first = -1;
        for (int k = 0; k < NUM_CH; k++) begin
            hits[k] = retire_valid && m_en[k] && ((retire_instr & m_mask[k]) == m_val[k]);
            if (hits[k] && first < 0) first = k;
        end
        pop = (exp_q.size() != 0) && trace_ready;
        if (clr) begin
            for (int k = 0; k < NUM_CH; k++) begin m_cnt[k] = 0; m_ovf[k] = 0; end
            m_drop = 0;
            exp_q.delete();
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (hits[k]) begin
                    if (m_cnt[k] == CNT_MAX) m_ovf[k] = 1;
                    else m_cnt[k] = m_cnt[k] + 1;
                end
            end
            if (pop) void'(exp_q.pop_front());
            if (first >= 0) begin
                if (exp_q.size() < FIFO_DEPTH) begin
                    r.pc = retire_pc; r.instr = retire_instr; r.ch = first;
                    exp_q.push_back(r);
                end else if (m_drop < DROP_MAX) begin
                    m_drop = m_drop + 1;
                end
            end
        end
        if (cfg_we) begin
            m_en[cfg_ch] = cfg_en; m_mask[cfg_ch] = cfg_mask; m_val[cfg_ch] = cfg_value;
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compares every output against the model; walks cfg_ch over all
    // channels to read each counter, then restores it (takes 4 time units).
    task automatic check_all(input string tag);
        logic [NUM_CH-1:0] e_ovf;
        logic [1:0]        saved;
        for (int k = 0; k < NUM_CH; k++) e_ovf[k] = m_ovf[k];
        chk({tag, ".valid"}, trace_valid_o, exp_q.size() != 0);
        chk({tag, ".level"}, fifo_level_o, exp_q.size());
        if (exp_q.size() != 0) begin
            chk({tag, ".pc"},    trace_pc_o,    exp_q[0].pc);
            chk({tag, ".instr"}, trace_instr_o, exp_q[0].instr);
            chk({tag, ".ch"},    trace_ch_o,    exp_q[0].ch);
        end else begin
            chk({tag, ".pc0"},    trace_pc_o,    0);
            chk({tag, ".instr0"}, trace_instr_o, 0);
            chk({tag, ".ch0"},    trace_ch_o,    0);
        end
        chk({tag, ".drop"}, drop_cnt_o, m_drop);
        chk({tag, ".ovf"},  ovf_o,      e_ovf);
        saved = cfg_ch;
        for (int k = 0; k < NUM_CH; k++) begin
            cfg_ch = 2'(k);
            #1;
            chk($sformatf("%s.cnt%0d", tag, k), cnt_o, m_cnt[k]);
        end
        cfg_ch = saved;
    endtask

    task automatic peek_cnt(input int ch, output logic [CNT_W-1:0] v);
        logic [1:0] saved;
        saved = cfg_ch;
        cfg_ch = 2'(ch);
        #1;
        v = cnt_o;
        cfg_ch = saved;
    endtask

    // ---------------------------------------------------------------- driver
    task automatic step(input string tag, input bit we, input int ch, input bit en,
                        input logic [31:0] mask, input logic [31:0] val, input bit c,
                        input bit valid, input logic [31:0] instr, input bit ready);
        cfg_we = we; cfg_ch = 2'(ch); cfg_en = en; cfg_mask = mask; cfg_value = val;
        clr = c; retire_valid = valid; retire_instr = instr;
        retire_pc = $urandom; trace_ready = ready;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic cfg_write(input int ch, input logic [31:0] mask, input logic [31:0] val);
        step("cfg", 1, ch, 1, mask, val, 0, 0, 0, 0);
    endtask

    task automatic retire(input string tag, input logic [31:0] instr, input bit ready);
        step(tag, 0, 0, 0, 0, 0, 0, 1, instr, ready);
    endtask

    task automatic idle(input string tag, input bit ready);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, ready);
    endtask

    task automatic clear();
        step("clr", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    logic [31:0] mask_pool  [6] = '{32'h0000707F, 32'hFE00707F, 32'h0000007F,
                                    32'hFE00707F, 32'h0000007F, 32'h00000000};
    logic [31:0] value_pool [6] = '{32'h00000013, 32'h00000033, 32'h00000013,
                                    32'h10000077, 32'h00000077, 32'h00000000};
    logic [31:0] instr_pool [5] = '{32'h00500093, 32'h00A00133, 32'h10208077,
                                    32'h12345677, 32'h00000000};

    // --------------------------------------------------------- test sequence
    initial begin
        logic [CNT_W-1:0] v;
        model_reset();

        // Reset state.
        #1;
        chk("rst.valid", trace_valid_o, 0);
        chk("rst.level", fifo_level_o, 0);
        chk("rst.cnt",   cnt_o, 0);
        chk("rst.ovf",   ovf_o, 0);
        chk("rst.drop",  drop_cnt_o, 0);
        chk("rst.pc",    trace_pc_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        // ADDI matching on ch0.
        cfg_write(0, 32'h0000707F, 32'h00000013);
        repeat (3) retire("addi", 32'h00500093, 0);
        retire("add", 32'h00A00133, 0);
        peek_cnt(0, v);
        chk("tp1.cnt0", v, 3);
        chk("tp1.level", fifo_level_o, 3);
        chk("tp1.ch", trace_ch_o, 0);
        repeat (4) idle("drain1", 1);

        // KADD16 and any P-opcode: both count, lowest index is reported.
        cfg_write(1, 32'hFE00707F, 32'h10000077);
        cfg_write(2, 32'h0000007F, 32'h00000077);
        retire("kadd16", 32'h10208077, 0);
        peek_cnt(1, v);
        chk("tp2.cnt1", v, 1);
        peek_cnt(2, v);
        chk("tp2.cnt2", v, 1);
        chk("tp2.ch", trace_ch_o, 1);
        idle("drain2", 1);

        // Counter saturation on an 8-bit counter.
        clear();
        cfg_write(0, 32'h0, 32'h0);
        repeat (255) retire("sat", 32'h0, 1);
        peek_cnt(0, v);
        chk("tp3.cnt255", v, 8'hFF);
        chk("tp3.ovf_pre", ovf_o, 0);
        retire("sat_ovf", 32'h0, 1);
        peek_cnt(0, v);
        chk("tp3.cnt_sat", v, 8'hFF);
        chk("tp3.ovf", ovf_o[0], 1);
        clear();
        peek_cnt(0, v);
        chk("tp3.cnt_clr", v, 0);
        chk("tp3.ovf_clr", ovf_o, 0);

        // Full FIFO: drops, then push with simultaneous pop.
        repeat (6) retire("fill", 32'h0, 0);
        chk("tp4.level", fifo_level_o, 4);
        chk("tp4.drop", drop_cnt_o, 2);
        retire("push_pop", 32'h0, 1);
        chk("tp4.level_pp", fifo_level_o, 4);
        chk("tp4.drop_pp", drop_cnt_o, 2);

        // Config write coinciding with a retirement uses the old config.
        step("cfg_clr", 1, 0, 1, 32'h0000707F, 32'h00000013, 1, 0, 0, 1);
        step("cfg_race", 1, 0, 1, 32'h0000707F, 32'h00000033, 0, 1, 32'h00500093, 1);
        retire("race_addi", 32'h00500093, 1);
        retire("race_add", 32'h00A00133, 1);
        peek_cnt(0, v);
        chk("tp5.cnt0", v, 2);
        idle("drain5", 1);

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            int sel;
            bit we;
            bit valid;
            logic [31:0] instr;
            sel   = $urandom_range(0, 5);
            we    = ($urandom_range(0, 7) == 0);
            valid = ($urandom_range(0, 3) != 0);
            instr = ($urandom_range(0, 4) == 0) ? $urandom : instr_pool[$urandom_range(0, 4)];
            step("rand", we, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                 mask_pool[sel], value_pool[sel], $urandom_range(0, 49) == 0,
                 valid, instr, $urandom_range(0, 2) == 0);
        end

        // Asynchronous reset with records queued and counters nonzero.
        clear();
        cfg_write(0, 32'h0, 32'h0);
        repeat (5) retire("prefill", 32'h0, 0);
        idle("pop_one", 1);
        chk("tp6.level_pre", fifo_level_o, 3);
        chk("tp6.drop_pre", drop_cnt_o, 1);
        trace_ready = 0;
        cfg_ch = 0;
        #2;
        rst = 1;
        #1;
        chk("tp6.valid", trace_valid_o, 0);
        chk("tp6.level", fifo_level_o, 0);
        chk("tp6.cnt",   cnt_o, 0);
        chk("tp6.drop",  drop_cnt_o, 0);
        chk("tp6.ovf",   ovf_o, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        idle("post_rst", 0);
        retire("post_rst_cfg", 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cv32e40p_instr_match_unit.md
# cv32e40p_instr_match_unit

Parametrised instruction-match and trace-capture unit on the cv32e40p retire stream. It has NUM_CH runtime-programmable mask/value match channels, which replace fixed compile-time instruction masks. Each channel has a saturating occurrence counter with a sticky overflow flag. Matched retirements are buffered in a FIFO of trace records toward a debug/trace sink with ready/valid flow control, and records that cannot be stored are counted.

## Interface
Parameters:
- NUM_CH, 4: number of match channels (1..16)
- CNT_W, 32: per-channel counter width (8..32)
- FIFO_DEPTH, 8: trace FIFO entries (power of 2, 2..64)
- DROP_W, 16: dropped-record counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous assert, active-high
- cfg_we_i  in  1  write config of channel cfg_ch_i
- cfg_ch_i  in  $clog2(NUM_CH)  channel to configure / counter to read
- cfg_en_i  in  1  channel enable value
- cfg_mask_i  in  32  instruction bit mask
- cfg_value_i  in  32  compare value, applied after masking
- clr_i  in  1  clear counters, overflow flags, drop count; flush FIFO
- retire_valid_i  in  1  one instruction retired this cycle
- retire_instr_i  in  32  retired instruction word
- retire_pc_i  in  32  retired PC
- cnt_o  out  CNT_W  counter of channel cfg_ch_i
- ovf_o  out  NUM_CH  sticky per-channel counter saturation flags
- trace_valid_o  out  1  FIFO head valid
- trace_ready_i  in  1  sink accepts head
- trace_pc_o  out  32  head record PC
- trace_instr_o  out  32  head record instruction
- trace_ch_o  out  $clog2(NUM_CH)  lowest-index matching channel of head record
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  occupied entries
- drop_cnt_o  out  DROP_W  saturating count of discarded records

## Operation
- Channel k hits when retire_valid_i, en[k] is set, and (retire_instr_i & mask[k]) == value[k].
- Every hitting channel increments its counter by 1.
- Counter saturation: a counter at all-ones stays at all-ones and sets ovf[k]. ovf[k] clears only via clr_i or reset.
- Trace push: if any channel hits, push the record {pc, instr, lowest hitting index} into the FIFO.
- Push when FIFO is full:
  - If a pop occurs the same cycle, the push succeeds and the level is unchanged.
  - Otherwise the record is dropped and drop_cnt increments, saturating at all-ones.
- Pop: occurs when trace_valid_o && trace_ready_i.
- Config write: updates en/mask/value of cfg_ch_i at the clock edge. A retirement in the same cycle is matched against the old config.
- clr_i has priority over every same-cycle increment and push:
  - Counters, ovf and drop_cnt are zeroed.
  - FIFO pointers are reset.
  - The same-cycle pop is ignored.
  - Channel config is unchanged.
- Reset values:
  - All channels: en=0, mask=0, value=0.
  - Counters=0, ovf_o=0, drop_cnt_o=0.
  - FIFO empty: trace_valid_o=0, fifo_level_o=0.
  - trace_pc_o/trace_instr_o/trace_ch_o=0 while empty.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Pending records are lost; they are not counted as drops.

## Timing
- Counter, ovf and drop_cnt update at the edge following the retire cycle; cnt_o reflects the update 1 cycle after retirement.
- cnt_o is a combinational mux of counter registers on cfg_ch_i, with no extra latency.
- Trace latency is 1 cycle from push to trace_valid_o, with no same-cycle bypass.
  - Example: a push into an empty FIFO while trace_ready_i=1 appears at the head the next cycle.
- The head record is stable while trace_valid_o && !trace_ready_i.
- Throughput: one push and one pop per cycle, sustained indefinitely.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.

## Test plan
- Program ch0 mask=0x0000707F value=0x00000013 en=1 (ADDI). Retire 0x00500093 three times, then 0x00A00133 (ADD) once. Required: cnt_o(ch0)=3; 3 trace records with trace_ch_o=0.
- Program ch1 mask=0xFE00707F value=0x10000077 (KADD16) and ch2 mask=0x0000007F value=0x00000077 (any P-opcode), both enabled. Retire 0x10208077. Required: both counters=1; one record with trace_ch_o=1.
- CNT_W=8, counter preloaded by 255 matches, then 1 more match. Required: cnt_o=0xFF, ovf_o[0]=1. Then clr_i: cnt_o=0, ovf_o=0.
- FIFO_DEPTH=4, trace_ready_i=0, retire 6 matches. Required: fifo_level_o=4, drop_cnt_o=2. Then push with simultaneous pop: level stays 4, no drop.
- Config write to ch0 (value changed to 0x00000033) in the same cycle as retiring 0x00500093. Required: that retirement counts. The next 0x00500093 does not count; 0x00A00133 does.
- Assert rst_i asynchronously with 3 records queued and counters nonzero. Required: trace_valid_o=0, fifo_level_o=0, cnt_o=0, drop_cnt_o=0 before the next clock edge.
